// File: rtl/switch_led_pkg.sv
// Shared encodings for the switch/LED board controller: FSM states and the
// fixed LED patterns shown during the power-up lamp test and sweep.
package switch_led_pkg;

  typedef enum logic [1:0] {
    LAMP  = 2'd0,
    SWEEP = 2'd1,
    LIVE  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // LED words are {led1, led2, led3}.
  localparam logic [2:0] LAMP_PAT   = 3'b111;
  localparam logic [2:0] SWEEP_PAT0 = 3'b100;
  localparam logic [2:0] SWEEP_PAT1 = 3'b010;
  localparam logic [2:0] SWEEP_PAT2 = 3'b001;

endpackage

// File: rtl/switch_led_ctrl_debounce.sv
// Two-flop synchroniser plus whole-word debouncer: the output only follows the
// synchronised input after it has differed from it for DEB_CYCLES samples.
module sw_debounce #(
  parameter int WIDTH      = 1,
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] deb_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of the others; blocking here would collapse the
  // synchroniser chain into a single flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      // A different non-equal value mid-count keeps counting rather than
      // restarting; only a return to the debounced value clears the count.
      if (sync2_q == deb_q) begin
        cnt_q <= '0;
      end else if (cnt_q == DEB_LAST) begin
        deb_q <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign dout = deb_q;

endmodule

// File: rtl/switch_led_ctrl.sv
// Board controller: debounces the switch banks and mode button, runs a lamp
// test and LED sweep after reset, then shows the three LED functions live or frozen.
module switch_led_ctrl
  import switch_led_pkg::*;
#(
  parameter int DEB_CYCLES  = 4,
  parameter int LAMP_CYCLES = 8,
  parameter int STEP_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sw_or,
  input  logic [3:0] sw_nand,
  input  logic [3:0] sw_fn,
  input  logic       btn_mode,
  output logic       led1,
  output logic       led2,
  output logic       led3,
  output logic [1:0] mode
);

  localparam logic [CNT_W-1:0] LAMP_LAST  = CNT_W'(LAMP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STEP_1     = CNT_W'(STEP_CYCLES);
  localparam logic [CNT_W-1:0] STEP_2     = CNT_W'(2 * STEP_CYCLES);
  localparam logic [CNT_W-1:0] SWEEP_LAST = CNT_W'(3 * STEP_CYCLES - 1);

  logic [2:0] or_deb;
  logic [3:0] nand_deb;
  logic [3:0] fn_deb;
  logic       btn_deb;
  logic       btn_q;
  logic       btn_evt;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       leds_q, leds_d;
  logic [2:0]       live_leds;

  sw_debounce #(.WIDTH(3), .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_or (
    .clk(clk), .rst(rst), .din(sw_or), .dout(or_deb)
  );

  sw_debounce #(.WIDTH(4), .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_nand (
    .clk(clk), .rst(rst), .din(sw_nand), .dout(nand_deb)
  );

  sw_debounce #(.WIDTH(4), .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_fn (
    .clk(clk), .rst(rst), .din(sw_fn), .dout(fn_deb)
  );

  sw_debounce #(.WIDTH(1), .DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_btn (
    .clk(clk), .rst(rst), .din(btn_mode), .dout(btn_deb)
  );

  // fn bits are {A, B, C, D}.
  function automatic logic [2:0] eval_leds(input logic [2:0] o,
                                           input logic [3:0] n,
                                           input logic [3:0] f);
    logic a, b, c, d;
    {a, b, c, d} = f;
    return {|o, ~&n, (~a & d) | (~a & c) | (b & d) | (a & ~b & ~d)};
  endfunction

  function automatic logic [2:0] sweep_pat(input logic [CNT_W-1:0] c);
    if (c < STEP_1)      return SWEEP_PAT0;
    else if (c < STEP_2) return SWEEP_PAT1;
    else                 return SWEEP_PAT2;
  endfunction

  assign live_leds = eval_leds(or_deb, nand_deb, fn_deb);
  assign btn_evt   = btn_deb & ~btn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LAMP;
      cnt_q   <= '0;
      leds_q  <= '0;
      btn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      leds_q  <= leds_d;
      btn_q   <= btn_deb;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    leds_d  = leds_q;
    unique case (state_q)
      LAMP: begin
        leds_d = LAMP_PAT;
        // The first cycle after reset only loads the lamp pattern, so the
        // count covers exactly LAMP_CYCLES cycles of all-on.
        if (leds_q == LAMP_PAT) begin
          if (cnt_q == LAMP_LAST) begin
            state_d = SWEEP;
            cnt_d   = '0;
            leds_d  = SWEEP_PAT0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      SWEEP: begin
        if (cnt_q == SWEEP_LAST) begin
          state_d = LIVE;
          cnt_d   = '0;
          leds_d  = live_leds;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          leds_d = sweep_pat(cnt_d);
        end
      end
      LIVE: begin
        leds_d = live_leds;
        if (btn_evt) state_d = HOLD;
      end
      HOLD: begin
        if (btn_evt) begin
          state_d = LIVE;
          leds_d  = live_leds;
        end
      end
      default: state_d = LAMP;
    endcase
  end

  assign {led1, led2, led3} = leds_q;
  assign mode               = state_q;

endmodule
